// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: configurable data width, parity and stop bits,
// valid/ready input handshake, registered serial output with busy/done status.
module uart_tx_cfg #(
   parameter int CLK_FREQ  = 50000000,
   parameter int UART_BPS  = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 uart_txd,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam int BW      = 4;
   localparam logic [CW-1:0] CNT_MAX   = CW'(BPS_CNT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = (STOP_BITS == 2) ? BW'(1) : BW'(0);
   localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
   localparam bit PAR_ODD = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [CW-1:0]        clk_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 txd_nx;
   logic                 done_nx;
   logic                 bit_end;
   logic                 last_data;
   logic                 last_stop;

   assign bit_end   = (clk_cnt == CNT_MAX);
   assign last_data = (bit_cnt == DATA_LAST);
   assign last_stop = (bit_cnt == STOP_LAST);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (tx_valid) state_nx = S_START;
         S_START:  if (bit_end) state_nx = S_DATA;
         S_DATA:   if (bit_end && last_data) state_nx = PAR_EN ? S_PARITY : S_STOP;
         S_PARITY: if (bit_end) state_nx = S_STOP;
         S_STOP:   if (bit_end && last_stop) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Output decode looks one bit ahead so uart_txd stays a plain register.
   always_comb begin
      txd_nx  = uart_txd;
      done_nx = 1'b0;
      case (state)
         S_IDLE:   txd_nx = ~tx_valid;
         S_START:  if (bit_end) txd_nx = shreg[0];
         S_DATA:   if (bit_end) txd_nx = last_data ? (PAR_EN ? par_bit : 1'b1) : shreg[1];
         S_PARITY: if (bit_end) txd_nx = 1'b1;
         S_STOP: begin
            txd_nx  = 1'b1;
            done_nx = bit_end && last_stop;
         end
         default:  txd_nx = 1'b1;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else if (state == S_IDLE) begin
         clk_cnt <= '0;
         bit_cnt <= '0;
         if (tx_valid) begin
            shreg   <= tx_data;
            par_bit <= PAR_ODD ? ~^tx_data : ^tx_data;
         end
      end else begin
         clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
         if (state_nx != state) begin
            bit_cnt <= '0;
         end else if (bit_end) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (state == S_DATA && bit_end) begin
            shreg <= shreg >> 1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         uart_txd <= 1'b1;
         tx_ready <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         uart_txd <= txd_nx;
         tx_ready <= (state_nx == S_IDLE);
         tx_busy  <= (state_nx != S_IDLE);
         tx_done  <= done_nx;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8N1, 8E1, 8O1 and 7N2 instances at 10 clocks/bit.
module tb_uart_tx_cfg;

   logic       sys_clk;
   logic       sys_rst;
   logic       tx_valid;
   logic [7:0] tx_data8;
   logic [6:0] tx_data7;
   logic [3:0] txd;
   logic [3:0] ready;
   logic [3:0] busy;
   logic [3:0] done;

   int checks;
   int errors;

   logic [10:0] frame [4];
   int          nbits [4];
   logic [10:0] f_a;
   logic [10:0] f_b;
   int          done_cnt;

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_valid(tx_valid), .tx_data(tx_data8),
      .tx_ready(ready[0]), .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));
   uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_valid(tx_valid), .tx_data(tx_data8),
      .tx_ready(ready[1]), .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));
   uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_valid(tx_valid), .tx_data(tx_data8),
      .tx_ready(ready[2]), .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));
   uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_valid(tx_valid), .tx_data(tx_data7),
      .tx_ready(ready[3]), .uart_txd(txd[3]), .tx_busy(busy[3]), .tx_done(done[3]));

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d t=%0t: got %0h expected %0h", tag, idx, $time, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      sys_rst  = 1'b1;
      tx_valid = 1'b0;
      tx_data8 = '0;
      tx_data7 = '0;
      // Frames as bit k at index k: {stop(s), parity, data LSB-first, start}.
      frame[0] = {2'b01, 8'hA5, 1'b0};       nbits[0] = 10;
      frame[1] = {1'b1, 1'b0, 8'hA5, 1'b0};  nbits[1] = 11;
      frame[2] = {1'b1, 1'b1, 8'hA5, 1'b0};  nbits[2] = 11;
      frame[3] = {1'b0, 2'b11, 7'h7F, 1'b0}; nbits[3] = 10;

      // Reset state
      repeat (3) @(posedge sys_clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rst_txd", i, 32'(txd[i]), 32'd1);
         chk("rst_ready", i, 32'(ready[i]), 32'd1);
         chk("rst_busy", i, 32'(busy[i]), 32'd0);
         chk("rst_done", i, 32'(done[i]), 32'd0);
      end
      @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      // Single frame on every instance, inputs scrambled mid-frame
      tx_valid = 1'b1;
      tx_data8 = 8'hA5;
      tx_data7 = 7'h7F;
      @(posedge sys_clk);
      #1;
      tx_valid = 1'b0;
      for (int c = 0; c < 116; c++) begin
         if (c > 0) begin
            @(posedge sys_clk);
            #1;
         end
         for (int i = 0; i < 4; i++) begin
            chk("frame_txd", i, 32'((c < nbits[i]*10) ? frame[i][c/10] : 1'b1), 32'(txd[i]));
            chk("frame_done", i, 32'(done[i]), 32'(c == nbits[i]*10));
            chk("frame_ready", i, 32'(ready[i]), 32'(c >= nbits[i]*10));
            chk("frame_busy", i, 32'(busy[i]), 32'(c < nbits[i]*10));
         end
         if (c >= 20 && c <= 80) begin
            tx_valid = (c < 80) && c[0];
            tx_data8 = 8'($urandom);
            tx_data7 = 7'($urandom);
         end
      end

      // Back-to-back on the 8N1 instance: 0x00 then 0xFF
      @(negedge sys_clk);
      tx_valid = 1'b1;
      tx_data8 = 8'h00;
      tx_data7 = 7'h00;
      f_a = {2'b01, 8'h00, 1'b0};
      f_b = {2'b01, 8'hFF, 1'b0};
      done_cnt = 0;
      @(posedge sys_clk);
      #1;
      tx_data8 = 8'hFF;
      for (int c = 0; c < 206; c++) begin
         if (c > 0) begin
            @(posedge sys_clk);
            #1;
         end
         if (c < 100)
            chk("b2b_txd_a", 0, 32'(txd[0]), 32'(f_a[c/10]));
         else if (c == 100)
            chk("b2b_gap", 0, 32'(txd[0]), 32'd1);
         else if (c < 201)
            chk("b2b_txd_b", 0, 32'(txd[0]), 32'(f_b[(c-101)/10]));
         else
            chk("b2b_idle", 0, 32'(txd[0]), 32'd1);
         if (c == 100) chk("b2b_ready_gap", 0, 32'(ready[0]), 32'd1);
         if (c == 101) begin
            chk("b2b_ready_acc", 0, 32'(ready[0]), 32'd0);
            tx_valid = 1'b0;
         end
         if (c == 100 || c == 201) chk("b2b_done_at", 0, 32'(done[0]), 32'd1);
         if (done[0]) done_cnt++;
      end
      chk("b2b_done_count", 0, 32'(done_cnt), 32'd2);
      repeat (20) @(posedge sys_clk);

      // Reset in the middle of a frame
      @(negedge sys_clk);
      tx_valid = 1'b1;
      tx_data8 = 8'h00;
      tx_data7 = 7'h00;
      @(posedge sys_clk);
      #1;
      tx_valid = 1'b0;
      repeat (45) @(posedge sys_clk);
      #1;
      for (int i = 0; i < 4; i++) chk("pre_rst_txd", i, 32'(txd[i]), 32'd0);
      #2;
      sys_rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) chk("async_rst_txd", i, 32'(txd[i]), 32'd1);
      repeat (2) @(posedge sys_clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rst_mid_done", i, 32'(done[i]), 32'd0);
         chk("rst_mid_ready", i, 32'(ready[i]), 32'd1);
         chk("rst_mid_busy", i, 32'(busy[i]), 32'd0);
      end
      @(negedge sys_clk);
      sys_rst  = 1'b0;
      tx_valid = 1'b1;
      tx_data8 = 8'hA5;
      tx_data7 = 7'h7F;
      @(posedge sys_clk);
      #1;
      tx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("post_rst_start", i, 32'(txd[i]), 32'd0);
         chk("post_rst_ready", i, 32'(ready[i]), 32'd0);
         chk("post_rst_busy", i, 32'(busy[i]), 32'd1);
         chk("post_rst_done", i, 32'(done[i]), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
